fft_twiddle_sequencer: RTL
==========================

Name: fft_twiddle_sequencer

Overview:
- Drives an in-place radix-2 decimation-in-time FFT.
- Each handshake beat issues one butterfly descriptor: RAM addresses of operand A and operand B, plus twiddle factor W_N^t (real and imaginary, Q1.15).
- The twiddle and operand-B data feed the 16-bit inputs of the complex multiplier.
- Sits between the FFT control path and the multiplier/butterfly datapath; stalls on downstream back-pressure and inserts an idle gap between stages so results can be written back.

Parameters:
- LOG2N, 4, log2 of FFT length N (N=16 by default; legal 2..10).
- STAGE_GAP, 4, idle cycles (o_valid low) between the last beat of one stage and the first beat of the next; 0 is legal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  begin a full transform; sampled only in IDLE.
- i_ready  in  1  downstream accepts the current descriptor.
- o_valid  out  1  descriptor outputs valid.
- o_addr_a  out  LOG2N  RAM address of operand A.
- o_addr_b  out  LOG2N  RAM address of operand B (always o_addr_a + 2^stage).
- o_tw_r  out  16  twiddle real part, signed Q1.15.
- o_tw_c  out  16  twiddle imaginary part, signed Q1.15.
- o_stage  out  clog2(LOG2N)  stage of the current descriptor.
- o_last  out  1  current descriptor is the final beat of the transform.
- o_busy  out  1  high in any state other than IDLE.
- o_done  out  1  one-cycle pulse when the transform completes.

Behaviour:
- Reset: every output register is 0, the FSM goes to IDLE, and the stage, butterfly and gap counters clear. An asserted reset mid-transform aborts immediately; no o_done is produced.
- FSM states: IDLE, RUN, GAP, DONE.
  - IDLE -> RUN on i_start. i_start is ignored in all other states.
  - RUN: output registers load the next descriptor whenever (!o_valid || i_ready). A beat is accepted on (o_valid && i_ready).
  - RUN -> GAP on acceptance of the last beat of a non-final stage, only when STAGE_GAP > 0. With STAGE_GAP = 0, the next stage's first descriptor loads on the same edge.
  - GAP holds o_valid low for exactly STAGE_GAP cycles, then returns to RUN with the stage incremented.
  - RUN -> DONE on acceptance of the beat with o_last = 1.
  - DONE: o_done = 1 for one cycle, then IDLE.
- Latency: i_start is sampled at edge T; the first descriptor is valid after edge T+1.
- Descriptor math, for stage s in 0..LOG2N-1 and butterfly k in 0..N/2-1 (k increments per accepted beat):
  - half = 2^s, j = k & (half-1), g = k >> s
  - addr_a = g*2*half + j, addr_b = addr_a + half
  - twiddle index t = j << (LOG2N-1-s)
  - W_N^t = cos(2*pi*t/N) - j*sin(2*pi*t/N), rounded to nearest Q1.15
  - +1.0 saturates to 0x7FFF; -1.0 is 0x8000
- Stalls: while o_valid && !i_ready, all descriptor outputs hold stable and the counters do not advance.
- Beat count: exactly LOG2N*N/2 beats per transform, with no duplicates and no skips.
- Transform duration with i_ready held high: (LOG2N*N/2) + (LOG2N-1)*STAGE_GAP cycles of busy issue.
- o_busy: asserts after the edge that samples i_start and deasserts on the edge leaving DONE.
- o_last: high only on the final beat (s = LOG2N-1, k = N/2-1).

Decomposition:
- Shared package fft_pkg holds:
  - Q1.15 constants: ONE=0x7FFF, MINUS_ONE=0x8000.
  - FSM state encodings (IDLE/RUN/GAP/DONE).
  - Default LOG2N.
- Sub-module fft_twiddle_rom:
  - Combinational lookup, index t (LOG2N-1 bits) -> {tw_r, tw_c}.
  - Table of N/2 entries generated at elaboration.
  - The sequencer registers its outputs.

Test Plan:
- Reset then i_start (N=16, STAGE_GAP=4, i_ready=1):
  - First beat: addr_a=0, addr_b=1, tw=0x7FFF/0x0000, stage 0.
  - Second beat: addr_a=2, addr_b=3.
  - 32 beats plus 12 gap cycles total; o_done pulses once.
- Stage 1 beats 0..1: (0,2,t=0) then (1,3,t=4) with tw_r=0x0000, tw_c=0x8000.
- Stage 3, k=2: addr_a=2, addr_b=10, tw_r=0x5A82, tw_c=0xA57E. Beat k=7 has o_last=1.
- i_ready low for 5 cycles on beat 3 of stage 2: outputs frozen for 5 cycles. The next accepted beat is k=4, with no beat skipped or repeated.
- rst asserted mid stage 1: all outputs are 0 immediately and no o_done. A fresh i_start restarts at stage 0, k=0.
- i_start pulsed while busy: ignored, and the beat count stays 32. With STAGE_GAP=0, the beats are back-to-back across stage boundaries.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT twiddle sequencer.
// Includes the FSM states, Q1.15 constants and elaboration-time twiddle quantisation.
package fft_pkg;

  localparam int unsigned DEFAULT_LOG2N = 4;

  localparam logic [15:0] Q15_ONE       = 16'h7FFF;
  localparam logic [15:0] Q15_MINUS_ONE = 16'h8000;

  localparam real PI = 3.14159265358979323846;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] c;
  } tw_t;

  // Round to nearest Q1.15; +1.0 cannot be represented and saturates.
  function automatic logic [15:0] q15(input real x);
    real v;
    v = x * 32768.0;
    if (v > 32767.0) return Q15_ONE;
    if (v <= -32768.0) return Q15_MINUS_ONE;
    return 16'($rtoi($floor(v + 0.5)));
  endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// Combinational twiddle lookup: index t -> W_N^t = cos(2*pi*t/N) - j*sin(2*pi*t/N).
// The N/2-entry table is computed at elaboration.
module fft_twiddle_rom
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N = DEFAULT_LOG2N
) (
  input  logic [LOG2N-2:0] idx,
  output tw_t              tw
);

  localparam int unsigned HALF = 2 ** (LOG2N - 1);
  localparam int unsigned N    = 2 ** LOG2N;

  tw_t rom [HALF];

  for (genvar i = 0; i < HALF; i++) begin : g_tab
    localparam real         ANG = 2.0 * PI * real'(i) / real'(N);
    localparam logic [15:0] TR  = q15($cos(ANG));
    localparam logic [15:0] TC  = q15(-$sin(ANG));
    assign rom[i] = {TR, TC};
  end

  assign tw = rom[idx];

endmodule

// File: rtl/fft_twiddle_sequencer.sv
// Issues one butterfly descriptor (operand addresses + twiddle) per handshake beat
// for an in-place radix-2 DIT FFT, with an idle gap between stages.
module fft_twiddle_sequencer
  import fft_pkg::*;
#(
  parameter int unsigned LOG2N     = DEFAULT_LOG2N,
  parameter int unsigned STAGE_GAP = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_start,
  input  logic                      i_ready,
  output logic                      o_valid,
  output logic [LOG2N-1:0]          o_addr_a,
  output logic [LOG2N-1:0]          o_addr_b,
  output logic [15:0]               o_tw_r,
  output logic [15:0]               o_tw_c,
  output logic [$clog2(LOG2N)-1:0]  o_stage,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned AW = LOG2N;
  localparam int unsigned KW = LOG2N - 1;
  localparam int unsigned SW = $clog2(LOG2N);
  localparam int unsigned GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [GW-1:0] G_LAST = GW'(STAGE_GAP - 1);

  state_t        state_q, state_n;
  logic [SW-1:0] s_q, s_n, ld_s;
  logic [KW-1:0] k_q, k_n, ld_k;
  logic [GW-1:0] gap_q, gap_n;
  logic          valid_n;
  logic          load;

  logic [AW-1:0] kk, mask, j, addr_a, addr_b;
  logic [SW-1:0] sh;
  logic [KW-1:0] t_idx;
  tw_t           tw;

  // s_q/k_q name the descriptor in the output registers, or the next one to load when o_valid is low.
  always_comb begin
    state_n = state_q;
    s_n     = s_q;
    k_n     = k_q;
    gap_n   = gap_q;
    valid_n = o_valid;
    load    = 1'b0;
    ld_s    = s_q;
    ld_k    = k_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_n = ST_RUN;
          s_n     = '0;
          k_n     = '0;
        end
      end
      ST_RUN: begin
        if (!o_valid) begin
          load    = 1'b1;
          valid_n = 1'b1;
        end else if (i_ready) begin
          if (o_last) begin
            state_n = ST_DONE;
            valid_n = 1'b0;
          end else if (k_q == K_LAST) begin
            s_n = s_q + SW'(1);
            k_n = '0;
            if (STAGE_GAP > 0) begin
              state_n = ST_GAP;
              gap_n   = '0;
              valid_n = 1'b0;
            end else begin
              load = 1'b1;
              ld_s = s_q + SW'(1);
              ld_k = '0;
            end
          end else begin
            k_n  = k_q + KW'(1);
            load = 1'b1;
            ld_k = k_q + KW'(1);
          end
        end
      end
      ST_GAP: begin
        // Preload the next stage's first beat on the last gap cycle so o_valid stays low exactly STAGE_GAP cycles.
        if (gap_q == G_LAST) begin
          state_n = ST_RUN;
          load    = 1'b1;
          valid_n = 1'b1;
        end else begin
          gap_n = gap_q + GW'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Address split: bits of k at or above s move up one place to make room for the half-span bit.
  always_comb begin
    kk     = AW'(ld_k);
    mask   = (AW'(1) << ld_s) - AW'(1);
    j      = kk & mask;
    addr_a = ((kk & ~mask) << 1) | j;
    addr_b = addr_a | (AW'(1) << ld_s);
    sh     = S_LAST - ld_s;
    t_idx  = KW'(j) << sh;
  end

  fft_twiddle_rom #(.LOG2N(LOG2N)) u_rom (
    .idx (t_idx),
    .tw  (tw)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      k_q      <= '0;
      gap_q    <= '0;
      o_valid  <= 1'b0;
      o_addr_a <= '0;
      o_addr_b <= '0;
      o_tw_r   <= '0;
      o_tw_c   <= '0;
      o_stage  <= '0;
      o_last   <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      k_q     <= k_n;
      gap_q   <= gap_n;
      o_valid <= valid_n;
      o_busy  <= (state_n != ST_IDLE);
      o_done  <= (state_n == ST_DONE);
      if (load) begin
        o_addr_a <= addr_a;
        o_addr_b <= addr_b;
        o_tw_r   <= tw.r;
        o_tw_c   <= tw.c;
        o_stage  <= ld_s;
        o_last   <= (ld_s == S_LAST) && (ld_k == K_LAST);
      end
    end
  end

endmodule
